// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman shared-key engine:
// default widths, controller state encoding and the fixed operation latency.
package dh_pkg;

  localparam int W_DEF = 32;
  localparam int E_DEF = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    BASE = 3'd2,
    SQR  = 3'd3,
    MUL  = 3'd4,
    FIN  = 3'd5
  } dh_state_e;

  // One base reduction plus a square and a multiply per exponent bit,
  // each W+1 cycles, plus the LOAD and FIN cycles.
  function automatic int dh_latency(input int w, input int e);
    return (2 * e + 1) * (w + 1) + 2;
  endfunction

  localparam int LAT = dh_latency(W_DEF, E_DEF);

endpackage

// File: rtl/dh_mod_mult_serial.sv
// Bit-serial Blakley modular multiplier: result = a*b mod p, a scanned MSB first.
// Fixed W+1 cycles per operation (launch + W steps); requires b < p, a unrestricted.
module dh_mod_mult_serial #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic [W-1:0] result,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W+1:0]  step;
  logic [W+1:0]  p_ext;
  logic [W+1:0]  sub1;
  logic [W-1:0]  sub2;

  // 2R + bit*B stays below 3p, so two conditional subtractions fully reduce it.
  always_comb begin
    p_ext = {2'b00, p_q};
    step  = {1'b0, r_q, 1'b0} + (a_q[W-1] ? {2'b00, b_q} : '0);
    sub1  = (step >= p_ext) ? (step - p_ext) : step;
    sub2  = (sub1 >= p_ext) ? W'(sub1 - p_ext) : W'(sub1);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      a_d    = a;
      b_d    = b;
      p_d    = p;
      r_d    = '0;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      r_d   = sub2;
      a_d   = {a_q[W-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign result = r_q;
  assign done   = done_q;

endmodule

// File: rtl/dh_shared_key.sv
// Diffie-Hellman responder: key = r_in^x mod p by constant-time square-and-multiply.
// Latency (2E+1)(W+1)+2 clocks from st accept to done; st ignored while busy.
module dh_shared_key
  import dh_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int E = E_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st,
  input  logic [W-1:0] r_in,
  input  logic [E-1:0] x,
  input  logic [W-1:0] p,
  output logic [W-1:0] key,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int IW = (E > 1) ? $clog2(E) : 1;

  dh_state_e     state_q, state_d;

  logic [W-1:0]  r_q, r_d;
  logic [E-1:0]  x_q, x_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  base_q, base_d;
  logic [W-1:0]  t_q, t_d;
  logic [IW-1:0] i_q, i_d;
  logic [W-1:0]  key_q, key_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          perr_q, perr_d;

  logic          mul_start;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [W-1:0]  mul_res;
  logic          mul_done;
  logic [W-1:0]  acc_next;

  dh_mod_mult_serial #(.W(W)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (mul_a),
    .b      (mul_b),
    .p      (p_q),
    .result (mul_res),
    .done   (mul_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      x_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      t_q     <= '0;
      i_q     <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      x_q     <= x_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      t_q     <= t_d;
      i_q     <= i_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (st) state_d = LOAD;
      LOAD:    state_d = BASE;
      BASE:    if (mul_done) state_d = SQR;
      SQR:     if (mul_done) state_d = MUL;
      MUL:     if (mul_done) state_d = (i_q == '0) ? FIN : SQR;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The next operation is launched in the same cycle the previous result
  // appears, so every state spends exactly W+1 cycles per multiply.
  always_comb begin
    r_d       = r_q;
    x_d       = x_q;
    p_d       = p_q;
    acc_d     = acc_q;
    base_d    = base_q;
    t_d       = t_q;
    i_d       = i_q;
    key_d     = key_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    perr_d    = perr_q;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    acc_next  = x_q[i_q] ? mul_res : t_q;
    case (state_q)
      IDLE: begin
        if (st) begin
          r_d    = r_in;
          x_d    = x;
          p_d    = p;
          busy_d = 1'b1;
          err_d  = 1'b0;
        end
      end
      LOAD: begin
        // A degenerate modulus still runs the full schedule; only the result is suppressed.
        perr_d    = (p_q < W'(2));
        acc_d     = W'(1);
        i_d       = IW'(E - 1);
        mul_start = 1'b1;
        mul_a     = r_q;
        mul_b     = W'(1);
      end
      BASE: begin
        if (mul_done) begin
          base_d    = mul_res;
          mul_start = 1'b1;
          mul_a     = acc_q;
          mul_b     = acc_q;
        end
      end
      SQR: begin
        if (mul_done) begin
          t_d       = mul_res;
          mul_start = 1'b1;
          mul_a     = mul_res;
          mul_b     = base_q;
        end
      end
      MUL: begin
        if (mul_done) begin
          acc_d = acc_next;
          if (i_q != '0) begin
            i_d       = i_q - IW'(1);
            mul_start = 1'b1;
            mul_a     = acc_next;
            mul_b     = acc_next;
          end
        end
      end
      FIN: begin
        key_d  = perr_q ? '0 : acc_q;
        err_d  = perr_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign key  = key_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dh_shared_key.sv
// Directed bench for dh_shared_key: table of hand-computed vectors plus
// sequences for st-while-busy, operand changes while busy and mid-run reset.
module tb_dh_shared_key;

  localparam int LAT_EXP = 2147;
  localparam int NV      = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [31:0] r_in;
  logic [31:0] x;
  logic [31:0] p;
  logic [31:0] key;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] r_in;
    logic [31:0] x;
    logic [31:0] p;
    logic [31:0] key;
    logic        err;
  } vec_t;

  vec_t vecs [NV];

  dh_shared_key dut (
    .clk  (clk),
    .rst  (rst),
    .st   (st),
    .r_in (r_in),
    .x    (x),
    .p    (p),
    .key  (key),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [31:0] ri, input logic [31:0] xi, input logic [31:0] pi,
                        output int t0);
    @(negedge clk);
    r_in = ri;
    x    = xi;
    p    = pi;
    st   = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    t0 = cyc_cnt;
  endtask

  task automatic wait_done(input int t0, output int lat);
    while (done !== 1'b1 && (cyc_cnt - t0) < LAT_EXP + 100) begin
      @(posedge clk);
      #1;
    end
    lat = cyc_cnt - t0;
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    int lat;
    logic [31:0] key_at_done;
    accept(v.r_in, v.x, v.p, t0);
    chk({v.name, "_busy_at_accept"}, {31'b0, busy}, 32'd1);
    chk({v.name, "_err_cleared"}, {31'b0, err}, 32'd0);
    wait_done(t0, lat);
    chk({v.name, "_latency"}, lat, LAT_EXP);
    chk({v.name, "_key"}, key, v.key);
    chk({v.name, "_err"}, {31'b0, err}, {31'b0, v.err});
    chk({v.name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    key_at_done = key;
    @(posedge clk);
    #1;
    chk({v.name, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({v.name, "_key_hold"}, key, v.key);
  endtask

  initial begin
    int t0;
    int lat;
    logic seen;

    vecs[0]  = '{"textbook",   32'd19,         32'd6,          32'd23,         32'd2,          1'b0};
    vecs[1]  = '{"unreduced",  32'd100,        32'd1,          32'd23,         32'd8,          1'b0};
    vecs[2]  = '{"wide",       32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFB,  32'd16,         1'b0};
    vecs[3]  = '{"x_zero",     32'd7,          32'd0,          32'd11,         32'd1,          1'b0};
    vecs[4]  = '{"r_zero",     32'd0,          32'd5,          32'd11,         32'd0,          1'b0};
    vecs[5]  = '{"p_one",      32'd5,          32'd3,          32'd1,          32'd0,          1'b1};
    vecs[6]  = '{"p_zero",     32'd5,          32'd3,          32'd0,          32'd0,          1'b1};
    vecs[7]  = '{"after_err",  32'd5,          32'd3,          32'd13,         32'd8,          1'b0};
    vecs[8]  = '{"pow2_32",    32'd2,          32'd32,         32'hFFFF_FFFB,  32'd5,          1'b0};
    vecs[9]  = '{"neg_one",    32'hFFFF_FFFA,  32'd3,          32'hFFFF_FFFB,  32'hFFFF_FFFA,  1'b0};
    vecs[10] = '{"x_ones",     32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  32'd1,          1'b0};

    rst  = 1'b1;
    st   = 1'b0;
    r_in = '0;
    x    = '0;
    p    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_key", key, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // st re-pulsed and operands altered while busy: original job must finish untouched.
    accept(32'd19, 32'd6, 32'd23, t0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    st   = 1'b1;
    r_in = 32'd5;
    x    = 32'd7;
    p    = 32'd97;
    repeat (3) @(negedge clk);
    st = 1'b0;
    wait_done(t0, lat);
    chk("midst_latency", lat, LAT_EXP);
    chk("midst_key", key, 32'd2);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1 || done === 1'b1) seen = 1'b1;
    end
    chk("midst_no_requeue", {31'b0, seen}, 32'd0);
    chk("midst_key_hold", key, 32'd2);

    // Reset 500 cycles into a run aborts it with no done pulse.
    accept(32'd100, 32'd1, 32'd23, t0);
    while ((cyc_cnt - t0) < 500) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_key", key, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT_EXP + 50; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", {31'b0, seen}, 32'd0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
